i2c_axi_reader: RTL and testbench
=================================

Name: i2c_axi_reader

Overview:
- AXI4-Lite master sequencer that drives the I2C front-end register block from fabric logic, with no CPU involved.
- On a start pulse it writes DEV_ADDR, REG_NUM and READ_LEN, polls STATUS until the transfer completes, then reads RX_DATA.
- Returns the data and a result code on a single-cycle done strobe.
- Sits between local control logic and the S_AXI port of the I2C register block.

Parameters:
- BASE_ADDR, 32'h0, byte address of the I2C register block.
- POLL_GAP, 8, idle clocks between consecutive STATUS reads (minimum 1).
- TIMEOUT_POLLS, 1000, maximum STATUS reads before aborting. Used only when the timeout feature is compiled in.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- i_start  in  1  one-cycle request; sampled only in IDLE
- i_dev_addr  in  7  I2C device address
- i_reg_num  in  8  device register number
- i_read_len  in  3  bytes to read, 1..4
- o_busy  out  1  high from the cycle after an accepted start until o_done
- o_done  out  1  one-cycle completion strobe
- o_result  out  2  0=OK, 1=AXI error, 2=I2C fault, 3=timeout; valid with o_done, held until the next o_done
- o_rx_data  out  32  RX_DATA value; valid with o_done when o_result=0, held until the next o_done
- M_AXI_AWADDR out 32, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1, M_AXI_AWPROT out 3 (constant 0)
- M_AXI_WDATA out 32, M_AXI_WSTRB out 4 (constant 4'hF), M_AXI_WVALID out 1, M_AXI_WREADY in 1
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1
- M_AXI_ARADDR out 32, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1, M_AXI_ARPROT out 3 (constant 0)
- M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1

Behaviour:
- Register offsets from BASE_ADDR:
  - STATUS 0x04: bit0 = idle, bit1 = fault
  - RX_DATA 0x08
  - DEV_ADDR 0x0C
  - REG_NUM 0x10
  - READ_LEN 0x14
- Reset values:
  - All VALID and READY outputs = 0.
  - o_busy = 0, o_done = 0, o_result = 0, o_rx_data = 0.
  - State = IDLE; poll and gap counters = 0.
- Input latch: the accepted i_start latches i_dev_addr, i_reg_num and i_read_len. Write data is zero-extended to 32 bits.
- i_read_len of 0 or >4 is sent unchanged; range checking is the slave's job.
- Write transaction (one per register):
  - AWVALID and WVALID assert together, registered.
  - Each deasserts on its own handshake; AW and W may complete in either order or the same cycle.
  - Once both have completed, BREADY=1 until BVALID.
  - BRESP != 0 -> result 1, go to FINISH.
- Read transaction:
  - ARVALID until ARREADY.
  - Then RREADY=1 until RVALID; RDATA is captured in the RVALID cycle.
  - RRESP != 0 -> result 1, go to FINISH.
- States:
  - IDLE: on i_start, go to WR_DEV.
  - WR_DEV -> WR_REG -> WR_LEN: the three writes, strictly in that order. A write is not issued until the previous B response has been received.
  - POLL_WAIT: wait POLL_GAP clocks.
  - POLL_RD: read STATUS.
    - bit0=0: back to POLL_WAIT.
    - bit0=1 and bit1=1: result 2, go to FINISH.
    - bit0=1 and bit1=0: go to DATA_RD.
  - DATA_RD: read RX_DATA into o_rx_data; result 0; go to FINISH.
  - FINISH: o_done=1 for one cycle, o_busy=0, return to IDLE.
- The first STATUS read is issued no earlier than POLL_GAP clocks after the READ_LEN B handshake. This gives the front end time to drop idle.
- i_start while busy is ignored. Starts are not queued.
- At most one AXI transaction is outstanding at any time.
- Reset mid-transaction: all VALID and READY outputs drop in the reset cycle. No AXI transfer is completed after reset. The slave must be reset together with this block.
- Minimum latency, start to done, with zero-wait slave and first poll idle:
  - 3 writes × 3 clks
  - POLL_GAP
  - 2 reads × 2 clks
  - 2 clks
  - Total with POLL_GAP=8: 23 clks.

Optional Feature:
- Macro: I2C_READER_TIMEOUT_EN.
- Defined: a poll counter clears on start and increments on each STATUS read that returns bit0=0. When it reaches TIMEOUT_POLLS, the block goes to FINISH with result 3.
- Not defined: the block polls indefinitely and result 3 is never produced.

Test Plan:
- Zero-wait slave model, POLL_GAP=8, start with dev=0x50, reg=0x1A, len=2, STATUS=0x1 on the first poll, RX_DATA=0x0000BEEF:
  - Writes 0x50 @0x0C, 0x1A @0x10, 0x2 @0x14, in order.
  - done after 23 clks, result=0, rx_data=0x0000BEEF.
- Slave delays WREADY 3 clks after AWREADY on every write -> same write sequence and data; done 9 clks later than the zero-wait case.
- STATUS returns 0x0 ×5 then 0x1 -> exactly 6 STATUS reads spaced ≥8 clks apart, then one RX_DATA read, result=0.
- STATUS returns 0x3 -> no RX_DATA read; result=2.
- BRESP=2 on the REG_NUM write -> READ_LEN is never written; result=1.
- Timeout and reset checks:
  - With I2C_READER_TIMEOUT_EN and TIMEOUT_POLLS=4, STATUS stuck at 0 -> 4 reads, then result=3.
  - resetn low during POLL_RD -> ARVALID=0 next cycle, busy=0, done never pulses.

Source files
------------

// File: rtl/i2c_axi_reader_if.sv
// AXI4-Lite bundle between the I2C reader sequencer (master) and the I2C register block (slave).
interface i2c_axi_reader_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [2:0]  awprot;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [2:0]  arprot;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
           araddr, arvalid, arprot, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
           araddr, arvalid, arprot, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/i2c_axi_reader.sv
// AXI4-Lite master: writes DEV_ADDR/REG_NUM/READ_LEN, polls STATUS, reads RX_DATA, strobes o_done.
// Optional macro I2C_READER_TIMEOUT_EN aborts with result 3 after TIMEOUT_POLLS not-idle STATUS reads.
module i2c_axi_reader #(
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter int unsigned POLL_GAP      = 8,
  parameter int unsigned TIMEOUT_POLLS = 1000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_start,
  input  logic [6:0]           i_dev_addr,
  input  logic [7:0]           i_reg_num,
  input  logic [2:0]           i_read_len,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_result,
  output logic [31:0]          o_rx_data,
  i2c_axi_reader_if.master     m_axi
);
  localparam logic [31:0] OFF_STATUS = 32'h04;
  localparam logic [31:0] OFF_RX     = 32'h08;
  localparam logic [31:0] OFF_DEV    = 32'h0C;
  localparam logic [31:0] OFF_REG    = 32'h10;
  localparam logic [31:0] OFF_LEN    = 32'h14;
  localparam int          GW         = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DEV, S_WR_REG, S_WR_LEN, S_POLL_WAIT, S_POLL_RD, S_DATA_RD, S_FINISH
  } state_t;

  state_t        state;
  logic          issued;
  logic [GW-1:0] gap_cnt;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q;
  logic [2:0]    len_q;
  logic [31:0]   wr_off;
  logic [31:0]   wr_dat;

`ifdef I2C_READER_TIMEOUT_EN
  localparam int            PW        = (TIMEOUT_POLLS > 1) ? $clog2(TIMEOUT_POLLS) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(TIMEOUT_POLLS - 1);
  logic [PW-1:0] poll_cnt;
`endif

  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;
  assign m_axi.wstrb  = 4'hF;

  always_comb begin
    wr_off = OFF_DEV;
    wr_dat = {25'd0, dev_q};
    case (state)
      S_WR_REG: begin wr_off = OFF_REG; wr_dat = {24'd0, reg_q}; end
      S_WR_LEN: begin wr_off = OFF_LEN; wr_dat = {29'd0, len_q}; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      issued        <= 1'b0;
      gap_cnt       <= '0;
      dev_q         <= '0;
      reg_q         <= '0;
      len_q         <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_result      <= 2'd0;
      o_rx_data     <= 32'd0;
      m_axi.awaddr  <= 32'd0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= 32'd0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= 32'd0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
`ifdef I2C_READER_TIMEOUT_EN
      poll_cnt      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          dev_q  <= i_dev_addr;
          reg_q  <= i_reg_num;
          len_q  <= i_read_len;
          o_busy <= 1'b1;
          issued <= 1'b0;
          state  <= S_WR_DEV;
`ifdef I2C_READER_TIMEOUT_EN
          poll_cnt <= '0;
`endif
        end

        S_WR_DEV, S_WR_REG, S_WR_LEN: begin
          if (!issued) begin
            issued        <= 1'b1;
            m_axi.awvalid <= 1'b1;
            m_axi.wvalid  <= 1'b1;
            m_axi.awaddr  <= BASE_ADDR + wr_off;
            m_axi.wdata   <= wr_dat;
          end else if (m_axi.bready) begin
            if (m_axi.bvalid) begin
              m_axi.bready <= 1'b0;
              issued       <= 1'b0;
              if (m_axi.bresp != 2'b00) begin
                state <= S_FINISH; o_done <= 1'b1; o_busy <= 1'b0; o_result <= 2'd1;
              end else if (state == S_WR_DEV) begin
                state <= S_WR_REG;
              end else if (state == S_WR_REG) begin
                state <= S_WR_LEN;
              end else begin
                gap_cnt <= '0;
                state   <= S_POLL_WAIT;
              end
            end
          end else begin
            // AW and W retire independently; B is only accepted once both have.
            if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
            if (m_axi.wvalid && m_axi.wready)   m_axi.wvalid  <= 1'b0;
            if ((!m_axi.awvalid || m_axi.awready) && (!m_axi.wvalid || m_axi.wready))
              m_axi.bready <= 1'b1;
          end
        end

        S_POLL_WAIT: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= S_POLL_RD;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        S_POLL_RD, S_DATA_RD: begin
          if (!issued) begin
            issued        <= 1'b1;
            m_axi.arvalid <= 1'b1;
            m_axi.araddr  <= BASE_ADDR + ((state == S_POLL_RD) ? OFF_STATUS : OFF_RX);
          end else if (m_axi.arvalid) begin
            if (m_axi.arready) begin
              m_axi.arvalid <= 1'b0;
              m_axi.rready  <= 1'b1;
            end
          end else if (m_axi.rvalid) begin
            m_axi.rready <= 1'b0;
            issued       <= 1'b0;
            if (m_axi.rresp != 2'b00) begin
              state <= S_FINISH; o_done <= 1'b1; o_busy <= 1'b0; o_result <= 2'd1;
            end else if (state == S_DATA_RD) begin
              o_rx_data <= m_axi.rdata;
              state <= S_FINISH; o_done <= 1'b1; o_busy <= 1'b0; o_result <= 2'd0;
            end else if (!m_axi.rdata[0]) begin
`ifdef I2C_READER_TIMEOUT_EN
              if (poll_cnt == POLL_LAST) begin
                state <= S_FINISH; o_done <= 1'b1; o_busy <= 1'b0; o_result <= 2'd3;
              end else begin
                poll_cnt <= poll_cnt + 1'b1;
                state    <= S_POLL_WAIT;
              end
`else
              state <= S_POLL_WAIT;
`endif
            end else if (m_axi.rdata[1]) begin
              state <= S_FINISH; o_done <= 1'b1; o_busy <= 1'b0; o_result <= 2'd2;
            end else begin
              state <= S_DATA_RD;
            end
          end
        end

        S_FINISH: begin
          o_done <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_axi_reader.sv
// Bench for i2c_axi_reader: behavioural AXI-Lite slave, table vectors, randomized runs vs a transaction-level model.
module tb_i2c_axi_reader;
  localparam int GAP = 8;
  localparam int TP  = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_start = 1'b0;
  logic [6:0]  i_dev_addr = '0;
  logic [7:0]  i_reg_num = '0;
  logic [2:0]  i_read_len = '0;
  logic        o_busy, o_done;
  logic [1:0]  o_result;
  logic [31:0] o_rx_data;

  i2c_axi_reader_if axi();

  i2c_axi_reader #(.BASE_ADDR(32'h0), .POLL_GAP(GAP), .TIMEOUT_POLLS(TP)) dut (
    .clk(clk), .resetn(resetn), .i_start(i_start), .i_dev_addr(i_dev_addr),
    .i_reg_num(i_reg_num), .i_read_len(i_read_len), .o_busy(o_busy), .o_done(o_done),
    .o_result(o_result), .o_rx_data(o_rx_data), .m_axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [2:0]  len;
    int          wdly;   // WREADY lag after AW handshake
    int          err_wr; // 1..3 = write that gets BRESP=2, 0 = none
    int          nzero;  // STATUS reads returning not-idle before idle
    bit          fault;
    logic [31:0] junk;   // don't-care STATUS bits
    logic [31:0] rx;
  } scen_t;

  typedef struct { scen_t s; int res; int lat; } tv_t;
  typedef struct { int res; int lat; int nwr; int nstat; int nrx; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;

  // slave state and transaction logs
  int          cyc = 0;
  bit          aw_got, w_got, r_pend;
  int          aw_edge, last_b_edge;
  logic [31:0] aw_addr, w_data, rd_val;
  int          wdly, nzero, stat_idx, rx_reads, overlap;
  logic [31:0] err_addr, stat_busy, stat_final, rx_val;
  wr_t         wr_log[$];
  int          stat_edges[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Each write costs 3 clks plus the WREADY lag; each STATUS read costs the gap plus
  // 3 clks; the RX_DATA read costs 3 more; done rises on the final response edge.
  function automatic exp_t model(input scen_t s);
    exp_t e;
    e.nwr = (s.err_wr != 0) ? s.err_wr : 3;
    e.lat = e.nwr * (3 + s.wdly);
    e.nstat = 0; e.nrx = 0;
    if (s.err_wr != 0) begin e.res = 1; return e; end
`ifdef I2C_READER_TIMEOUT_EN
    if (s.nzero >= TP) begin
      e.res = 3; e.nstat = TP; e.lat += TP * (GAP + 3); return e;
    end
`endif
    e.nstat = s.nzero + 1;
    e.lat  += e.nstat * (GAP + 3);
    if (s.fault) e.res = 2;
    else begin e.res = 0; e.nrx = 1; e.lat += 3; end
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!resetn) begin
      aw_got = 0; w_got = 0; r_pend = 0;
    end else begin
      if ((axi.awvalid || axi.wvalid || axi.bready) && (axi.arvalid || axi.rready)) overlap++;
      if (axi.awvalid && axi.awready) begin aw_got = 1; aw_addr = axi.awaddr; aw_edge = cyc; end
      if (axi.wvalid && axi.wready) begin w_got = 1; w_data = axi.wdata; end
      if (axi.bvalid && axi.bready) begin
        wr_log.push_back('{aw_addr, w_data});
        aw_got = 0; w_got = 0; last_b_edge = cyc;
      end
      if (axi.rvalid && axi.rready) r_pend = 0;
      if (axi.arvalid && axi.arready) begin
        r_pend = 1;
        if (axi.araddr == 32'h4) begin
          stat_edges.push_back(cyc);
          rd_val = (stat_idx < nzero) ? stat_busy : stat_final;
          stat_idx++;
        end else begin
          rx_reads++;
          rd_val = rx_val;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
      axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    end else begin
      axi.awready = !aw_got;
      axi.wready  = !w_got && (wdly == 0 || (aw_got && (cyc + 1 - aw_edge) >= wdly));
      axi.bvalid  = aw_got && w_got;
      axi.bresp   = (aw_addr == err_addr) ? 2'b10 : 2'b00;
      axi.arready = !r_pend;
      axi.rvalid  = r_pend;
      axi.rdata   = rd_val;
      axi.rresp   = 2'b00;
    end
  end

  task automatic setup_slave(input scen_t s);
    wdly = s.wdly; nzero = s.nzero; stat_idx = 0; rx_reads = 0;
    err_addr   = (s.err_wr != 0) ? (32'h8 + 32'(4 * s.err_wr)) : 32'hFFFF_FFFF;
    stat_busy  = s.junk & ~32'h1;
    stat_final = (s.junk & ~32'h3) | (s.fault ? 32'h3 : 32'h1);
    rx_val     = s.rx;
    wr_log.delete(); stat_edges.delete();
  endtask

  task automatic run(input scen_t s, input bit poke, output int res, output int lat);
    exp_t e;
    int t0, mingap, ok;
    bit got;
    logic [31:0] ed[3];
    e = model(s);
    setup_slave(s);
    @(negedge clk);
    i_dev_addr = s.dev; i_reg_num = s.rg; i_read_len = s.len; i_start = 1;
    @(negedge clk);
    i_start = 0; t0 = cyc;
    check("busy_after_start", {31'd0, o_busy}, 32'd1);
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (o_done) got = 1;
      else begin
        i_start = (poke && i == 2);
        @(negedge clk);
      end
    end
    i_start = 0;
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      res = -1; lat = -1;
      return;
    end
    lat = cyc - t0;
    res = int'(o_result);
    if (e.res == 0) check("rx_data", o_rx_data, s.rx);
    @(negedge clk);
    check("done_one_cycle", {30'd0, o_done, o_busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("n_writes", wr_log.size(), e.nwr);
    ed[0] = {25'd0, s.dev}; ed[1] = {24'd0, s.rg}; ed[2] = {29'd0, s.len};
    ok = 1;
    for (int k = 0; k < wr_log.size() && k < e.nwr; k++)
      if (wr_log[k].a !== 32'(12 + 4 * k) || wr_log[k].d !== ed[k]) ok = 0;
    check("write_seq", ok, 1);
    check("n_status_reads", stat_edges.size(), e.nstat);
    check("n_rx_reads", rx_reads, e.nrx);
    if (stat_edges.size() > 0) begin
      mingap = stat_edges[0] - last_b_edge;
      for (int k = 1; k < stat_edges.size(); k++)
        if (stat_edges[k] - stat_edges[k-1] < mingap) mingap = stat_edges[k] - stat_edges[k-1];
      check("poll_spacing_ok", mingap >= GAP, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tv_t   tbl[7];
    scen_t s;
    exp_t  e;
    int    res, lat, waited;
    bit    seen;

    tbl[0] = '{'{7'h50, 8'h1A, 3'd2, 0, 0, 0, 1'b0, 32'h0, 32'h0000BEEF}, 0, 23};
    tbl[1] = '{'{7'h50, 8'h1A, 3'd2, 3, 0, 0, 1'b0, 32'h0, 32'h0000BEEF}, 0, 32};
    tbl[2] = '{'{7'h50, 8'h1A, 3'd2, 0, 0, 5, 1'b0, 32'h0, 32'h12345678}, 0, 78};
    tbl[3] = '{'{7'h50, 8'h1A, 3'd2, 0, 0, 0, 1'b1, 32'h0, 32'h0}, 2, 20};
    tbl[4] = '{'{7'h50, 8'h1A, 3'd2, 0, 2, 0, 1'b0, 32'h0, 32'h0}, 1, 6};
    tbl[5] = '{'{7'h7F, 8'hFF, 3'd0, 0, 0, 0, 1'b0, 32'h0, 32'hCAFEF00D}, 0, 23};
    tbl[6] = '{'{7'h01, 8'h00, 3'd7, 0, 1, 0, 1'b0, 32'h0, 32'h0}, 1, 3};

    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    overlap = 0; last_b_edge = 0; rd_val = 0; aw_addr = 0; w_data = 0;
    wdly = 0; nzero = 0; stat_idx = 0; rx_reads = 0;
    err_addr = 32'hFFFF_FFFF; stat_busy = 0; stat_final = 1; rx_val = 0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {o_busy, o_done, o_result, o_rx_data}, 36'd0);
    check("reset_axi_handshake",
          {27'd0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 32'd0);
    resetn = 1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].s, 1'b0, res, lat);
      check($sformatf("tbl%0d_result", i), res, tbl[i].res);
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
    end

`ifdef I2C_READER_TIMEOUT_EN
    s = '{7'h50, 8'h1A, 3'd2, 0, 0, 50, 1'b0, 32'h0, 32'h0};
    run(s, 1'b0, res, lat);
    check("timeout_result", res, 3);
    check("timeout_latency", lat, 9 + TP * (GAP + 3));
`endif

    for (int i = 0; i < 24; i++) begin
      s.dev    = 7'($urandom);
      s.rg     = 8'($urandom);
      s.len    = 3'($urandom);
      s.wdly   = $urandom_range(0, 2);
      s.err_wr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      s.nzero  = $urandom_range(0, 5);
      s.fault  = ($urandom_range(0, 3) == 0);
      s.junk   = $urandom;
      s.rx     = $urandom;
      e = model(s);
      run(s, e.lat > 10, res, lat);
      check($sformatf("rand%0d_result", i), res, e.res);
      check($sformatf("rand%0d_latency", i), lat, e.lat);
    end

    // reset while a STATUS read is on the bus
    s = '{7'h22, 8'h33, 3'd1, 0, 0, 1000, 1'b0, 32'h0, 32'h0};
    setup_slave(s);
    @(negedge clk);
    i_dev_addr = s.dev; i_reg_num = s.rg; i_read_len = s.len; i_start = 1;
    @(negedge clk);
    i_start = 0;
    waited = 0;
    while (!(axi.arvalid && axi.araddr == 32'h4) && waited < 200) begin
      @(negedge clk); waited++;
    end
    check("rst_reached_poll", waited < 200, 1);
    resetn = 0;
    @(negedge clk);
    check("rst_arvalid_low", {31'd0, axi.arvalid}, 32'd0);
    check("rst_busy_low", {31'd0, o_busy}, 32'd0);
    resetn = 1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done) seen = 1;
    end
    check("rst_no_done", {31'd0, seen}, 32'd0);
    check("rst_idle_bus", {28'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.rready}, 32'd0);
    check("one_outstanding", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
